// File: rtl/nibble_add_sequencer_if.sv
// Bundles the operand request, adder stage and result channels of the nibble add sequencer.
// slave is the sequencer's view; master is the surrounding environment's view.
interface nibble_add_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;

  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;
  logic         add_ovf;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  modport slave (
    input  in_valid, op_a, op_b, op_sub, add_sum, add_cout, add_ovf, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, result, carry_out, overflow
  );

  modport master (
    output in_valid, op_a, op_b, op_sub, add_sum, add_cout, add_ovf, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, result, carry_out, overflow
  );
endinterface

// File: rtl/nibble_add_sequencer.sv
// Serialises a wide add/sub onto an external 4-bit adder, LSB nibble first, chaining carry
// between nibbles and returning the assembled result over a valid/ready handshake.
module nibble_add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  nibble_add_sequencer_if.slave   bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state, state_next;
  logic [IDX_W-1:0]         idx;
  logic [NIBBLES-1:0][3:0]  a_q, b_q, result_q;
  logic                     carry_q, carry_out_q, overflow_q;
  logic                     last;
  logic                     accept;

  assign last   = (idx == IDX_W'(NIBBLES - 1));
  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default before the case so no path infers a latch.
  always_comb begin
    state_next  = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.add_a     = '0;
    bus.add_b     = '0;
    bus.add_cin   = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = rst_n;
        if (bus.in_valid && rst_n) state_next = RUN;
      end
      RUN: begin
        bus.add_a   = a_q[idx];
        bus.add_b   = b_q[idx];
        bus.add_cin = carry_q;
        if (last) state_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      idx         <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Subtraction is A + ~B + 1: invert B once here, seed the carry with op_sub.
            a_q     <= bus.op_a;
            b_q     <= bus.op_b ^ {W{bus.op_sub}};
            carry_q <= bus.op_sub;
            idx     <= '0;
          end
        end
        RUN: begin
          result_q[idx] <= bus.add_sum;
          carry_q       <= bus.add_cout;
          idx           <= idx + 1'b1;
          if (last) begin
            carry_out_q <= bus.add_cout;
            overflow_q  <= bus.add_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Directed bench for nibble_add_sequencer with a behavioural 4-bit adder stage and a
// scoreboard of expected results derived from full-width integer arithmetic.
module tb_nibble_add_sequencer;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  nibble_add_sequencer_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_add_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Adder stage: combinational 4-bit add with signed overflow.
  logic [4:0] p2_full;
  assign p2_full     = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0, bus.add_cin};
  assign bus.add_sum  = p2_full[3:0];
  assign bus.add_cout = p2_full[4];
  assign bus.add_ovf  = (bus.add_a[3] == bus.add_b[3]) && (p2_full[3] != bus.add_a[3]);

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    exp_t e;
    int   sa, sbv, s;
    sa    = int'($signed(a));
    sbv   = int'($signed(b));
    s     = sub ? sa - sbv : sa + sbv;
    e.res = sub ? a - b : a + b;
    e.c   = sub ? (a >= b) : (((32'(a) + 32'(b)) >> W) != 0);
    e.v   = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
    return e;
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                      input bit push);
    int n;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_sub   = sub;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", 32'(n < 100), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (push) sb.push_back(model(a, b, sub));
  endtask

  // Waits for a result, compares it with the scoreboard, optionally stalls, then accepts it.
  task automatic recv(input int exp_lat, input int hold);
    int   lat;
    exp_t e;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_seen", 32'(bus.out_valid), 32'd1);
    if (exp_lat >= 0) check("latency", 32'(lat), 32'(exp_lat));
    check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("result", 32'(bus.result), 32'(e.res));
      check("carry_out", 32'(bus.carry_out), 32'(e.c));
      check("overflow", 32'(bus.overflow), 32'(e.v));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        check("hold_result", 32'(bus.result), 32'(e.res));
        check("hold_flags", 32'({bus.carry_out, bus.overflow}), 32'({e.c, e.v}));
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("valid_dropped", 32'(bus.out_valid), 32'd0);
    check("ready_after_done", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit quiet;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_sub    = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", 32'({bus.carry_out, bus.overflow}), 32'd0);
    check("rst_add_drives", 32'({bus.add_a, bus.add_b, bus.add_cin}), 32'd0);
    rst_n = 1'b1;
    #1 check("ready_after_rst", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // 1: simple add with latency
    send(16'h0001, 16'h0002, 1'b0, 1'b1);
    check("busy_in_run", 32'(bus.in_ready), 32'd0);
    recv(NIBBLES, 0);

    // 2: signed overflow
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    recv(NIBBLES, 0);

    // 3: carry ripples through every nibble
    send(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    for (int k = 0; k < NIBBLES; k++) begin
      check("ripple_cin", 32'(bus.add_cin), 32'(k > 0));
      @(negedge clk);
    end
    recv(-1, 0);

    // 4: subtraction with borrow, and signed overflow on subtract
    send(16'h0003, 16'h0005, 1'b1, 1'b1);
    recv(NIBBLES, 0);
    send(16'h8000, 16'h0001, 1'b1, 1'b1);
    recv(NIBBLES, 0);

    // 5: backpressure with a new request held off until the handshake completes
    send(16'h1234, 16'h4321, 1'b0, 1'b1);
    bus.op_a     = 16'hABCD;
    bus.op_b     = 16'h1111;
    bus.op_sub   = 1'b1;
    bus.in_valid = 1'b1;
    recv(NIBBLES, 5);
    send(16'hABCD, 16'h1111, 1'b1, 1'b1);
    recv(NIBBLES, 0);

    // Random mix
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      logic         rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(1));
      send(ra, rb, rs, 1'b1);
      recv(NIBBLES, 0);
    end

    // 6: reset while idx=2
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid_run_add_a", 32'(bus.add_a), 32'h1);
    check("mid_run_add_b", 32'(bus.add_b), 32'h2);
    check("mid_run_low_lanes", 32'(bus.result[7:0]), 32'h33);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_result", 32'(bus.result), 32'd0);
    check("rst_mid_drives", 32'({bus.add_a, bus.add_b, bus.add_cin}), 32'd0);
    check("rst_mid_flags", 32'({bus.carry_out, bus.overflow}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_mid_rst", 32'(bus.in_ready), 32'd1);
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) quiet = 1'b0;
    end
    check("no_stale_result", 32'(quiet), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
